// File: rtl/axi_ad7124_pkg.sv
// Shared types and helpers for the AD7124 thermocouple sample buffer.
package axi_ad7124_pkg;

  localparam int unsigned TC_WORD_W    = 32;
  localparam int unsigned ADC_DATA_W   = 24;
  localparam int unsigned ADC_STATUS_W = 8;
  localparam int unsigned ADC_CH_W     = 4;
  localparam int unsigned RD_ADDR_W    = 3;

  typedef enum logic {
    R_EMPTY = 1'b0,
    R_FULL  = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic [ADC_STATUS_W-1:0] status;
    logic [ADC_DATA_W-1:0]   data;
  } tc_word_t;

  function automatic tc_word_t pack_tc_word(input logic [ADC_STATUS_W-1:0] status,
                                            input logic [ADC_DATA_W-1:0]   data);
    tc_word_t w;
    w.status = status;
    w.data   = data;
    return w;
  endfunction

endpackage

// File: rtl/axi_ad7124_tc_buffer_if.sv
// Conversion-in and bank-read signals of one thermocouple buffer.
interface axi_ad7124_tc_buffer_if;
  import axi_ad7124_pkg::*;

  logic                    adc_valid;
  logic [ADC_CH_W-1:0]     adc_channel;
  logic [ADC_DATA_W-1:0]   adc_data;
  logic [ADC_STATUS_W-1:0] adc_status;
  logic                    bram_en;
  logic [RD_ADDR_W-1:0]    bram_addr;
  logic [TC_WORD_W-1:0]    bram_dout;
  logic                    valid;
  logic                    ready;

  modport master (
    output adc_valid, adc_channel, adc_data, adc_status, bram_en, bram_addr, ready,
    input  bram_dout, valid
  );

  modport slave (
    input  adc_valid, adc_channel, adc_data, adc_status, bram_en, bram_addr, ready,
    output bram_dout, valid
  );
endinterface

// File: rtl/axi_ad7124_tc_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with a zero-return option.
module axi_ad7124_tc_dpram
  import axi_ad7124_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  tc_word_t          wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rzero,
  output tc_word_t          rdata
);

  tc_word_t mem [DEPTH];

  // Storage array is intentionally left unreset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rzero ? tc_word_t'('0) : mem[raddr];
    end
  end

endmodule

// File: rtl/axi_ad7124_tc_buffer.sv
// Per-board thermocouple ping-pong buffer: gathers a full channel set, then hands it to the reader.
module axi_ad7124_tc_buffer
  import axi_ad7124_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        sync,
  axi_ad7124_tc_buffer_if.slave       bus,
  output logic [CNT_W-1:0]            stat_overrun_cnt,
  output logic [CNT_W-1:0]            stat_badch_cnt
);

  localparam int unsigned RAM_AW    = RD_ADDR_W + 1;
  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
  localparam int unsigned RD_EXT_W  = RD_ADDR_W + 1;

  rd_state_t          state, state_nxt;
  logic [NUM_CH-1:0]  mask, mask_nxt, mask_wr;
  logic               wr_bank, wr_bank_nxt;
  logic               valid_q;
  logic               ram_we;
  logic               overrun_inc, badch_inc;
  logic               ch_ok, rd_oob;
  tc_word_t           wr_word, rd_word;

  assign ch_ok   = bus.adc_channel < ADC_CH_W'(NUM_CH);
  assign rd_oob  = {1'b0, bus.bram_addr} >= RD_EXT_W'(NUM_CH);
  assign wr_word = pack_tc_word(bus.adc_status, bus.adc_data);

  // Capture, set completion, bank swap and read-side handoff.
  always_comb begin
    state_nxt   = state;
    mask_nxt    = mask;
    wr_bank_nxt = wr_bank;
    ram_we      = 1'b0;
    overrun_inc = 1'b0;
    badch_inc   = 1'b0;
    mask_wr     = mask;

    if (sync) begin
      mask_nxt  = '0;
      state_nxt = R_EMPTY;
    end else begin
      if (bus.adc_valid) begin
        if (ch_ok) begin
          ram_we  = 1'b1;
          mask_wr = mask | (NUM_CH'(1) << bus.adc_channel);
        end else begin
          badch_inc = 1'b1;
        end
      end

      if (state == R_FULL && bus.ready) begin
        state_nxt = R_EMPTY;
      end

      // Completion is judged on the mask including this cycle's write.
      if (&mask_wr) begin
        mask_nxt = '0;
        if (state == R_EMPTY || bus.ready) begin
          wr_bank_nxt = ~wr_bank;
          state_nxt   = R_FULL;
        end else begin
          overrun_inc = 1'b1;
        end
      end else begin
        mask_nxt = mask_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= R_EMPTY;
      mask             <= '0;
      wr_bank          <= 1'b0;
      valid_q          <= 1'b0;
      stat_overrun_cnt <= '0;
      stat_badch_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      mask    <= mask_nxt;
      wr_bank <= wr_bank_nxt;
      valid_q <= (state_nxt == R_FULL);
      if (overrun_inc && stat_overrun_cnt != '1) begin
        stat_overrun_cnt <= stat_overrun_cnt + CNT_W'(1);
      end
      if (badch_inc && stat_badch_cnt != '1) begin
        stat_badch_cnt <= stat_badch_cnt + CNT_W'(1);
      end
    end
  end

  axi_ad7124_tc_dpram #(
    .DEPTH  (RAM_DEPTH),
    .ADDR_W (RAM_AW)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (ram_we),
    .waddr  ({wr_bank, bus.adc_channel[RD_ADDR_W-1:0]}),
    .wdata  (wr_word),
    .re     (bus.bram_en),
    .raddr  ({~wr_bank, bus.bram_addr}),
    .rzero  (rd_oob),
    .rdata  (rd_word)
  );

  assign bus.valid     = valid_q;
  assign bus.bram_dout = rd_word;

endmodule

// File: doc/axi_ad7124_tc_buffer.md
Name: axi_ad7124_tc_buffer

Overview:
- Per-board thermocouple sample buffer, one instance per ADC board.
- Sits between the AD7124 SPI conversion engine (upstream) and the fusion/frame builder (downstream).
- Collects one conversion per channel into a ping-pong RAM. When a full set of NUM_CH channels is captured, it presents that set as a readable bank with a valid/ready handshake.
- Honours the multi-chip sync pulse by discarding partial data.

Parameters:
- NUM_CH, 8, channels per board; also the depth of each bank; must be ≤ 8.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- sync  in  1  multi-chip sync from frame builder; level, active-high
- adc_valid  in  1  one-cycle strobe: new conversion result present
- adc_channel  in  4  channel index of result
- adc_data  in  24  conversion code
- adc_status  in  8  AD7124 status byte for that conversion
- bram_en  in  1  read enable from frame builder
- bram_addr  in  3  read address (channel index)
- bram_dout  out  32  read data {adc_status, adc_data}; 1-cycle latency
- valid  out  1  a complete bank is available for reading
- ready  in  1  one-cycle pulse: consumer is done with the bank, release it
- stat_overrun_cnt  out  CNT_W  completed sets dropped because the read bank was still held
- stat_badch_cnt  out  CNT_W  results ignored because adc_channel ≥ NUM_CH

Behaviour:
- Reset values:
  - valid=0, bram_dout=0, both counters=0.
  - Write mask=0, write bank index wr_bank=0, read-side state R_EMPTY.
  - RAM contents are not reset.
- Storage: 2 banks × NUM_CH words × 32 bits. Read bank = ~wr_bank.
- Write side:
  - On adc_valid with adc_channel<NUM_CH and sync=0: write {status,data} to [wr_bank][channel] and set mask[channel].
  - A repeat channel before set completion overwrites the word; the mask is unchanged.
  - A channel ≥ NUM_CH: no write; stat_badch_cnt+1.
- Set completion: the mask has all NUM_CH bits set (evaluated including this cycle's write, i.e. on next-mask).
  - If the read side is R_EMPTY, or a ready pulse arrives in the same cycle: flip wr_bank, clear the mask, go to R_FULL. valid=1 from the next cycle.
  - Else (R_FULL and no ready): clear the mask with no flip; the set is dropped and stat_overrun_cnt+1.
- Read-side state machine:
  - R_EMPTY → R_FULL on a completion swap.
  - R_FULL → R_EMPTY on ready, unless a swap happens in the same cycle, in which case it stays R_FULL.
  - valid = (state==R_FULL), registered.
  - ready while R_EMPTY is ignored.
- Read port:
  - bram_dout <= RAM[read bank][bram_addr] when bram_en=1; otherwise it holds its previous value.
  - Addresses ≥ NUM_CH return 0.
  - Reads are legal regardless of valid; stale data is returned when empty.
- Sync (sync=1, every cycle):
  - Mask cleared, state→R_EMPTY, valid→0 next cycle, adc_valid ignored (not counted).
  - wr_bank is unchanged. Counters are unchanged.
- Simultaneous adc_valid completion + sync: sync wins; no write, no swap.
- Counters: saturate at all-ones; never wrap.
- Latency from the final channel write to valid=1: 1 cycle.
- Reset mid-set: everything returns to reset values next cycle; the partial set is lost.

Decomposition:
- Shared package axi_ad7124_pkg:
  - typedef rd_state_t {R_EMPTY, R_FULL}
  - localparam TC_WORD_W=32
  - function pack_tc_word(status, data)
- One natural sub-module: axi_ad7124_tc_dpram, a simple dual-port RAM (1 write, 1 registered read, depth 2×8, width 32) inferred as distributed/block RAM.

Test Plan:
- Reset, then write ch0..7 with data=0x100+ch, status=0x80 → valid=1 one cycle after the ch7 strobe; reading addr 0..7 returns 0x80000100..0x80000107 with 1-cycle latency.
- While valid=1 and no ready, write a second full set → no flip; reading still returns the first set; stat_overrun_cnt=1; valid stays 1.
- With valid=1, pulse ready in the same cycle as the 8th write of the next set (data 0x200+ch) → valid stays 1 continuously; reads return 0x80000200..; stat_overrun_cnt unchanged.
- Write ch0..3, assert sync 5 cycles, then write ch0..7 → valid only after the full post-sync set; ch0..3 pre-sync data is never visible; strobes during sync are uncounted.
- Strobe adc_channel=9 three times plus ch2 twice (0xAAA then 0xBBB) → stat_badch_cnt=3; completed bank ch2 reads 0x80000BBB.
- Force stat_overrun_cnt near saturation (2^CNT_W+3 dropped sets) → the counter holds at 0xFFFF and never wraps.
